// File: rtl/audio_clk_nco.sv
// audio_clk_nco: multi-channel phase-accumulator NCO producing ~50% duty
// audio clocks and per-period tick strobes from a single fabric clock.
// Increment updates go through a one-deep pending slot and take effect only
// on the target channel's wrap, or when it is stopped or disabled, so the
// output phase stays continuous and no runt pulse is produced.
module audio_clk_nco #(
    parameter int                     NCH      = 2,
    parameter int                     ACC_W    = 32,
    parameter logic [NCH*ACC_W-1:0]   INIT_INC = '0,
    parameter int                     LOCK_CYC = 1024
) (
    input  logic                                   clkin,
    input  logic                                   rst_n,
    input  logic                                   enable,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]                       cfg_inc,
    output logic [NCH-1:0]                         clk_out,
    output logic [NCH-1:0]                         tick,
    output logic                                   locked
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = $clog2(LOCK_CYC + 1);

    logic [ACC_W-1:0] acc_q [NCH];
    logic [ACC_W-1:0] acc_d [NCH];
    logic [ACC_W-1:0] inc_q [NCH];
    logic [ACC_W-1:0] inc_d [NCH];
    logic [ACC_W-1:0] sum   [NCH];
    logic [NCH-1:0]   carry;
    logic [NCH-1:0]   clk_out_q, clk_out_d;
    logic [NCH-1:0]   tick_q, tick_d;

    logic             pend_valid_q, pend_valid_d;
    logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
    logic [ACC_W-1:0] pend_inc_q, pend_inc_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;

    logic xfer, ch_ok, apply, all_run, pend_carry, pend_zero;

    // Per-channel phase addition; the carry out marks the end of a period.
    always_comb begin
        carry = '0;
        for (int c = 0; c < NCH; c++) begin
            {carry[c], sum[c]} = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
        end
    end

    // Handshake and decision whether the pending increment lands this cycle.
    always_comb begin
        xfer       = cfg_valid && !pend_valid_q;
        ch_ok      = (int'(cfg_ch) < NCH);
        pend_carry = 1'b0;
        pend_zero  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (int'(pend_ch_q) == c) begin
                pend_carry = carry[c];
                pend_zero  = (inc_q[c] == '0);
            end
        end
        // Only a slot captured in an earlier cycle can apply, so a capture
        // coinciding with a wrap waits for the next qualifying event.
        apply = pend_valid_q && (pend_carry || pend_zero || !enable);
    end

    // Next-state for accumulators, increments, outputs, pending slot and lock.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_ch_d    = pend_ch_q;
        pend_inc_d   = pend_inc_q;
        if (apply) begin
            pend_valid_d = 1'b0;
        end else if (xfer && ch_ok) begin
            pend_valid_d = 1'b1;
            pend_ch_d    = cfg_ch;
            pend_inc_d   = cfg_inc;
        end

        all_run   = 1'b1;
        clk_out_d = '0;
        tick_d    = '0;
        for (int c = 0; c < NCH; c++) begin
            inc_d[c] = inc_q[c];
            if (apply && (int'(pend_ch_q) == c)) begin
                inc_d[c] = pend_inc_q;
            end
            if (inc_q[c] == '0) begin
                all_run = 1'b0;
            end
            // The wrap addition uses the old increment; the phase is never reset on update.
            if (enable) begin
                acc_d[c]     = sum[c];
                clk_out_d[c] = sum[c][ACC_W-1];
                tick_d[c]    = carry[c];
            end else begin
                acc_d[c]     = '0;
            end
        end

        if (enable && !pend_valid_q && all_run && !(xfer && ch_ok)) begin
            lock_cnt_d = (lock_cnt_q == CNT_W'(LOCK_CYC)) ? lock_cnt_q
                                                          : lock_cnt_q + CNT_W'(1);
        end else begin
            lock_cnt_d = '0;
        end
        locked_d = (lock_cnt_q == CNT_W'(LOCK_CYC));
    end

    // State registers; reset restores the power-on increments and drops any pending update.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                acc_q[c] <= '0;
                inc_q[c] <= INIT_INC[c*ACC_W +: ACC_W];
            end
            clk_out_q    <= '0;
            tick_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_ch_q    <= '0;
            pend_inc_q   <= '0;
            lock_cnt_q   <= '0;
            locked_q     <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                acc_q[c] <= acc_d[c];
                inc_q[c] <= inc_d[c];
            end
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            pend_valid_q <= pend_valid_d;
            pend_ch_q    <= pend_ch_d;
            pend_inc_q   <= pend_inc_d;
            lock_cnt_q   <= lock_cnt_d;
            locked_q     <= locked_d;
        end
    end

    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign locked    = locked_q;
    assign cfg_ready = !pend_valid_q;

endmodule
